intra_delay_queue: RTL and testbench

//   Synthesizable stand-in for intra-assignment delays (lhs = #d rhs). Each accepted sample carries its own

---
 rtl/delay_pkg.sv | 16 +
 rtl/idq_ptr_ctl.sv | 43 ++++
 rtl/intra_delay_queue.sv | 83 ++++++++
 tb/tb_intra_delay_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared defaults and due-time helpers for the intra-delay queue
package delay_pkg;

  localparam int DELAY_W_DEF = 8;
  localparam int DATA_W_DEF  = 8;

  // Callers zero-extend and size-cast back to their own DELAY_W, so the add wraps there.
  function automatic logic [31:0] due_calc(input logic [31:0] now, input logic [31:0] d);
    return now + d;
  endfunction

  function automatic logic is_due(input logic [31:0] now, input logic [31:0] due);
    return now == due;
  endfunction

endpackage

// File: rtl/idq_ptr_ctl.sv
// rtl/idq_ptr_ctl.sv - read/write pointers, occupancy and push/pop qualification
module idq_ptr_ctl #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       out_valid,
  input  logic                       out_ready,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Full comes from registered count only, so a pop never frees space in its own cycle.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = in_valid && !full;
  assign pop   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/intra_delay_queue.sv
// rtl/intra_delay_queue.sv - in-order queue releasing each sample after its own cycle delay
module intra_delay_queue
  import delay_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DELAY_W-1:0]       in_delay,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DELAY_W-1:0] due_q  [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [DEPTH-1:0]   ripe;
  logic [DELAY_W-1:0] now;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;

  idq_ptr_ctl #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty && ripe[rd_ptr];
  assign out_data  = out_valid ? data_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= in_data;
      due_q[wr_ptr]  <= DELAY_W'(due_calc(32'(now), 32'(in_delay)));
    end
  end

  // Ripe is sticky so an entry stuck behind the head survives any number of counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now  <= '0;
      vld  <= '0;
      ripe <= '0;
    end else begin
      now <= now + 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && is_due(32'(now), 32'(due_q[i]))) ripe[i] <= 1'b1;
      end
      if (pop) begin
        vld[rd_ptr]  <= 1'b0;
        ripe[rd_ptr] <= 1'b0;
      end
      if (push) begin
        vld[wr_ptr]  <= 1'b1;
        ripe[wr_ptr] <= (in_delay == '0);
      end
    end
  end

endmodule

// File: tb/tb_intra_delay_queue.sv
// tb/tb_intra_delay_queue.sv - directed self-checking bench for intra_delay_queue
module tb_intra_delay_queue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_delay;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  intra_delay_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_delay  (in_delay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] dl);
    in_valid = 1'b1;
    in_data  = d;
    in_delay = dl;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_delay = 8'h00; out_ready = 1'b0;

    // 1 reset held with in_valid high
    repeat (5) begin
      tick();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_count", count, 4'd0);
      chk("rst_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    tick();
    chk("post_rst_count", count, 4'd0);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // 2 single sample, d=3 -> visible in cycle 4 only
    out_ready = 1'b1;
    push(8'hA5, 8'd3);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("single_valid_c%0d", c), out_valid, c == 4);
      if (c == 4) chk("single_data", out_data, 8'hA5);
      if (c == 5) chk("single_count", count, 4'd0);
      if (c < 5) tick();
    end

    // 3 arrival order kept even when the second sample is due first
    push(8'h11, 8'd5);
    tick();
    push(8'h22, 8'd0);
    tick();
    in_valid = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      chk($sformatf("order_valid_c%0d", c), out_valid, (c == 6) || (c == 7));
      if (c == 6) chk("order_data_c6", out_data, 8'h11);
      if (c == 7) chk("order_data_c7", out_data, 8'h22);
      tick();
    end

    // 4a due time wraps past 8'hFF
    while ((cyc % 256) != 254) tick();
    push(8'h33, 8'd4);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("wrap_valid_c%0d", c), out_valid, c == 5);
      if (c == 5) chk("wrap_data", out_data, 8'h33);
      tick();
    end

    // 4b d=255 entry stalled behind a held head across counter wraps
    out_ready = 1'b0;
    push(8'h77, 8'd0);
    tick();
    push(8'h88, 8'd255);
    tick();
    in_valid = 1'b0;
    repeat (600) tick();
    chk("stall_count", count, 4'd2);
    chk("stall_head_valid", out_valid, 1'b1);
    chk("stall_head_data", out_data, 8'h77);
    out_ready = 1'b1;
    chk("stall_hold_data", out_data, 8'h77);
    tick();
    chk("stall_second_valid", out_valid, 1'b1);
    chk("stall_second_data", out_data, 8'h88);
    tick();
    chk("stall_drain_valid", out_valid, 1'b0);
    chk("stall_drain_count", count, 4'd0);

    // 5 fill to full with downstream stalled, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h40 + i), 8'd0);
      chk($sformatf("full_in_ready_%0d", i), in_ready, i < 8);
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", count, 4'd8);
    chk("full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_valid_%0d", k), out_valid, 1'b1);
      chk($sformatf("drain_data_%0d", k), out_data, 8'(8'h40 + k));
      if (k == 0) chk("drain_in_ready_first", in_ready, 1'b0);
      if (k == 1) chk("drain_in_ready_second", in_ready, 1'b1);
      tick();
    end
    chk("drain_count", count, 4'd0);
    chk("drain_out_valid", out_valid, 1'b0);

    // 6 asynchronous reset with entries pending
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'(8'hA0 + i), 8'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_count", count, 4'd4);
    chk("mid_valid", out_valid, 1'b1);
    chk("mid_data", out_data, 8'hA0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_data", out_data, 8'h00);
    chk("async_count", count, 4'd0);
    chk("async_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    out_ready = 1'b1;
    push(8'h5A, 8'd0);
    chk("post_mid_c0_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("post_mid_c1_valid", out_valid, 1'b1);
    chk("post_mid_c1_data", out_data, 8'h5A);
    tick();
    chk("post_mid_count", count, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
